// File: rtl/multi_digit_display_scanner_if.sv
// ----------------------------------------------------------------------------
// multi_digit_display_scanner_if
// Purpose : groups the value/status inputs and the display pin outputs of the
//           multi-digit seven-segment scanner into one bundle.
// Signals : i_digits       4*NUM_DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//           i_dp           per-digit decimal point enable, active-high
//           i_blank_lz     1 = blank leading zeros
//           i_brightness   PWM duty, 0 = dark, all-ones = full on
//           o_segments     {dp,g,f,e,d,c,b,a}, polarity set by the scanner
//           o_digit_select one-hot anode enable, polarity set by the scanner
//           o_frame_tick   one-cycle pulse at each frame start
// Modports: master = upstream logic (drives values, observes pins)
//           slave  = scanner
// ----------------------------------------------------------------------------
interface multi_digit_display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIM_BITS   = 4
);

  logic [4*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    i_blank_lz;
  logic [DIM_BITS-1:0]     i_brightness;

  logic [7:0]              o_segments;
  logic [NUM_DIGITS-1:0]   o_digit_select;
  logic                    o_frame_tick;

  modport master (
    output i_digits,
    output i_dp,
    output i_blank_lz,
    output i_brightness,
    input  o_segments,
    input  o_digit_select,
    input  o_frame_tick
  );

  modport slave (
    input  i_digits,
    input  i_dp,
    input  i_blank_lz,
    input  i_brightness,
    output o_segments,
    output o_digit_select,
    output o_frame_tick
  );

endinterface

// File: rtl/multi_digit_display_scanner.sv
// ----------------------------------------------------------------------------
// multi_digit_display_scanner
// Purpose : time-multiplexed driver for an N-digit seven-segment display with
//           programmable slot length, per-digit decimal points, leading-zero
//           blanking, PWM brightness, a guard cycle at each slot start and
//           frame-coherent input snapshots.
// Ports   : i_clk  system clock
//           i_rst  asynchronous active-high reset
//           bus    multi_digit_display_scanner_if.slave
//                  (i_digits, i_dp, i_blank_lz, i_brightness in;
//                   o_segments, o_digit_select, o_frame_tick out)
// Timing  : outputs are registered; they reflect the scan position and PWM
//           phase of the previous cycle.
// ----------------------------------------------------------------------------
module multi_digit_display_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DIM_BITS       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic                         i_clk,
  input logic                         i_rst,
  multi_digit_display_scanner_if.slave bus
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  // XOR masks that turn active-high patterns into pin polarity; also the "off" levels.
  localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Scan state
  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [DIM_BITS-1:0]     r_pwm_phase;
  logic                    r_first_load;

  // Frame snapshot of the inputs
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic                    r_snap_blank_lz;
  logic [DIM_BITS-1:0]     r_snap_brightness;

  // Registered outputs
  logic [7:0]              r_segments;
  logic [NUM_DIGITS-1:0]   r_digit_select;
  logic                    r_frame_tick;

  logic                    w_slot_last;
  logic                    w_idx_last;
  logic                    w_end_of_frame;
  logic                    w_snap_load;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_nibble;
  logic                    w_digit_dp;
  logic                    w_digit_blank;
  logic                    w_pwm_on;
  logic                    w_en;
  logic [7:0]              w_seg_raw;
  logic [7:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
    endcase
    return pat;
  endfunction

  assign w_slot_last    = (r_slot_cnt == SLOT_LAST);
  assign w_idx_last     = (r_idx == IDX_LAST);
  assign w_end_of_frame = w_slot_last & w_idx_last;
  // The first clock after reset release loads a fresh snapshot; afterwards only
  // frame boundaries do, so a frame never mixes old and new values.
  assign w_snap_load    = r_first_load | w_end_of_frame;

  // Leading-zero mask: walk from the most significant digit downwards while all
  // nibbles seen so far are zero. Digit 0 always shows.
  always_comb begin
    logic all_zero;
    all_zero     = 1'b1;
    w_blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (r_snap_digits[4*k +: 4] == 4'h0);
      w_blank_mask[k] = r_snap_blank_lz & (k != 0) & all_zero;
    end
  end

  // Select the data of the digit currently being scanned.
  always_comb begin
    w_nibble      = 4'h0;
    w_digit_dp    = 1'b0;
    w_digit_blank = 1'b0;
    w_onehot      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble      = r_snap_digits[4*k +: 4];
        w_digit_dp    = r_snap_dp[k];
        w_digit_blank = w_blank_mask[k];
        w_onehot[k]   = 1'b1;
      end
    end
  end

  // All-ones brightness is forced on so full scale really is 100% duty.
  assign w_pwm_on   = (r_snap_brightness == '1) || (r_pwm_phase < r_snap_brightness);
  // Slot cycle 0 is a guard: anodes stay off while the segment pattern changes.
  assign w_en       = (r_slot_cnt != '0) && w_pwm_on;

  // A blanked digit keeps its decimal point.
  assign w_seg_raw  = {w_digit_dp, (w_digit_blank ? 7'h00 : seg_font(w_nibble))};
  assign w_seg_next = w_seg_raw ^ SEG_OFF;
  assign w_an_next  = (w_onehot & {NUM_DIGITS{w_en}}) ^ AN_OFF;

  // Slot counter, digit index and PWM phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_cnt  <= '0;
      r_idx       <= '0;
      r_pwm_phase <= '0;
    end else begin
      r_pwm_phase <= r_pwm_phase + DIM_BITS'(1);
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_idx      <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Input snapshot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_first_load      <= 1'b1;
      r_snap_digits     <= '0;
      r_snap_dp         <= '0;
      r_snap_blank_lz   <= 1'b0;
      r_snap_brightness <= '0;
    end else begin
      r_first_load <= 1'b0;
      if (w_snap_load) begin
        r_snap_digits     <= bus.i_digits;
        r_snap_dp         <= bus.i_dp;
        r_snap_blank_lz   <= bus.i_blank_lz;
        r_snap_brightness <= bus.i_brightness;
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_segments     <= SEG_OFF;
      r_digit_select <= AN_OFF;
      r_frame_tick   <= 1'b0;
    end else begin
      r_segments     <= w_seg_next;
      r_digit_select <= w_an_next;
      r_frame_tick   <= w_end_of_frame;
    end
  end

  assign bus.o_segments     = r_segments;
  assign bus.o_digit_select = r_digit_select;
  assign bus.o_frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_multi_digit_display_scanner.sv
module tb_multi_digit_display_scanner;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  multi_digit_display_scanner_if #(.NUM_DIGITS(N), .DIM_BITS(DB)) bus ();

  multi_digit_display_scanner #(
    .NUM_DIGITS    (N),
    .SCAN_DIV      (SD),
    .DIM_BITS      (DB),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: edges counted since reset release plus the snapshot in force.
  int          m_e;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [1:0]  m_br;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, m_e);
    end
  endtask

  // Outputs after an edge are a function of the scan position s = cycles since
  // release before that edge, and of the snapshot in force at that time.
  function automatic void model_expect(input int s, output logic [7:0] seg,
                                       output logic [3:0] ds, output logic ft);
    int         slot;
    int         idx;
    int         pwm;
    logic       lz;
    logic       blanked;
    logic [3:0] nib;
    slot = s % SD;
    idx  = (s / SD) % N;
    pwm  = s % (1 << DB);
    lz   = 1'b1;
    for (int k = N - 1; k >= idx; k--) if (m_dig[k*4 +: 4] != 4'h0) lz = 1'b0;
    blanked = m_blz && (idx != 0) && lz;
    nib     = m_dig[idx*4 +: 4];
    seg     = ~{m_dp[idx], (blanked ? 7'h00 : font[nib])};
    if (slot != 0 && (m_br == 2'd3 || pwm < int'(m_br))) ds = ~(4'b0001 << idx);
    else ds = 4'hF;
    ft = ((s % FRAME) == FRAME - 1);
  endfunction

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic step();
    logic [7:0] es;
    logic [3:0] ed;
    logic       eft;
    @(posedge clk);
    m_e++;
    model_expect(m_e - 1, es, ed, eft);
    if (m_e == 1 || (m_e % FRAME) == 0) begin
      m_dig = bus.i_digits;
      m_dp  = bus.i_dp;
      m_blz = bus.i_blank_lz;
      m_br  = bus.i_brightness;
    end
    @(negedge clk);
    chk("segments", {24'h0, bus.o_segments}, {24'h0, es});
    chk("digit_select", {28'h0, bus.o_digit_select}, {28'h0, ed});
    chk("frame_tick", {31'h0, bus.o_frame_tick}, {31'h0, eft});
  endtask

  task automatic run_to(input int e);
    while (m_e < e) step();
  endtask

  // Called away from the rising edge; outputs must drop at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_segments", {24'h0, bus.o_segments}, 32'hFF);
    chk("rst_digit_select", {28'h0, bus.o_digit_select}, 32'hF);
    chk("rst_frame_tick", {31'h0, bus.o_frame_tick}, 32'h0);
    m_e   = 0;
    m_dig = '0;
    m_dp  = '0;
    m_blz = 1'b0;
    m_br  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic b,
                        input logic [1:0] br);
    bus.i_digits     = d;
    bus.i_dp         = p;
    bus.i_blank_lz   = b;
    bus.i_brightness = br;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit exceeded, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    m_e = 0;
    set_in(16'h1234, 4'b0000, 1'b0, 2'd3);
    #2;
    do_reset();

    // Basic scan of 1234 at full brightness.
    run_to(1);  chk("lit_first_seg", {24'h0, bus.o_segments}, 32'hC0);
    run_to(16); chk("lit_tick16", {31'h0, bus.o_frame_tick}, 32'h1);
    run_to(17); chk("lit_guard_ds", {28'h0, bus.o_digit_select}, 32'hF);
    run_to(18); chk("lit_d0_ds", {28'h0, bus.o_digit_select}, 32'hE);
                chk("lit_d0_seg", {24'h0, bus.o_segments}, 32'h99);
    run_to(22); chk("lit_d1_ds", {28'h0, bus.o_digit_select}, 32'hD);
                chk("lit_d1_seg", {24'h0, bus.o_segments}, 32'hB0);
    run_to(26); chk("lit_d2_ds", {28'h0, bus.o_digit_select}, 32'hB);
                chk("lit_d2_seg", {24'h0, bus.o_segments}, 32'hA4);
    run_to(30); chk("lit_d3_ds", {28'h0, bus.o_digit_select}, 32'h7);
                chk("lit_d3_seg", {24'h0, bus.o_segments}, 32'hF9);
    run_to(32); chk("lit_tick32", {31'h0, bus.o_frame_tick}, 32'h1);

    // Leading-zero blanking.
    set_in(16'h0050, 4'b0000, 1'b1, 2'd3);
    do_reset();
    run_to(2);  chk("lz_d0", {24'h0, bus.o_segments}, 32'hC0);
    run_to(6);  chk("lz_d1", {24'h0, bus.o_segments}, 32'h92);
    run_to(10); chk("lz_d2", {24'h0, bus.o_segments}, 32'hFF);
    run_to(14); chk("lz_d3", {24'h0, bus.o_segments}, 32'hFF);
    set_in(16'h0000, 4'b0000, 1'b1, 2'd3);
    do_reset();
    run_to(2);  chk("zero_d0", {24'h0, bus.o_segments}, 32'hC0);
    run_to(6);  chk("zero_d1", {24'h0, bus.o_segments}, 32'hFF);
    run_to(14); chk("zero_d3", {24'h0, bus.o_segments}, 32'hFF);

    // Decimal point survives blanking.
    set_in(16'h0007, 4'b0100, 1'b1, 2'd3);
    do_reset();
    run_to(2);  chk("dp_d0", {24'h0, bus.o_segments}, 32'hF8);
    run_to(6);  chk("dp_d1", {24'h0, bus.o_segments}, 32'hFF);
    run_to(10); chk("dp_d2", {24'h0, bus.o_segments}, 32'h7F);

    // Mid-frame input change is held off until the next frame.
    set_in(16'h1111, 4'b0000, 1'b0, 2'd3);
    do_reset();
    run_to(6);  chk("coh_before", {24'h0, bus.o_segments}, 32'hF9);
    bus.i_digits = 16'h2222;
    run_to(10); chk("coh_held2", {24'h0, bus.o_segments}, 32'hF9);
    run_to(14); chk("coh_held3", {24'h0, bus.o_segments}, 32'hF9);
    run_to(16); chk("coh_tick", {31'h0, bus.o_frame_tick}, 32'h1);
    run_to(18); chk("coh_new", {24'h0, bus.o_segments}, 32'hA4);

    // Brightness.
    set_in(16'h8888, 4'b0000, 1'b0, 2'd0);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("br0_dark", {28'h0, bus.o_digit_select}, 32'hF);
    end
    set_in(16'h8888, 4'b0000, 1'b0, 2'd1);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("br1_dark", {28'h0, bus.o_digit_select}, 32'hF);
    end
    set_in(16'h8888, 4'b0000, 1'b0, 2'd2);
    do_reset();
    run_to(2);  chk("br2_on", {28'h0, bus.o_digit_select}, 32'hE);
    run_to(3);  chk("br2_off", {28'h0, bus.o_digit_select}, 32'hF);

    // Reset in the middle of digit 2's slot.
    set_in(16'h1234, 4'b0000, 1'b0, 2'd3);
    do_reset();
    run_to(10); chk("mid_ds_before", {28'h0, bus.o_digit_select}, 32'hB);
    do_reset();
    run_to(2);  chk("mid_restart_ds", {28'h0, bus.o_digit_select}, 32'hE);
    run_to(15); chk("mid_no_tick", {31'h0, bus.o_frame_tick}, 32'h0);
    run_to(16); chk("mid_tick", {31'h0, bus.o_frame_tick}, 32'h1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_in(16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom),
               1'($urandom), 2'($urandom));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
